rm_lane_release_tracker: RTL and testbench

Downstream companion of the runtime-monitor lane allocator. It consumes each lane-allocation descriptor, tracks the monitored load/store PCs held in every lane slot until they commit, and issues a one-cycle per-lane release pulse. The allocator uses that pulse as its `lane_reset_i` to free the lane. Flushes, hold-timer expiry and watchdog expiry also force releases.

---
 rtl/rm_lane_release_tracker_pkg.sv | 20 ++
 rtl/rm_lane_slot_fsm.sv | 106 ++++++++++
 rtl/rm_lane_release_tracker.sv | 75 +++++++
 tb/tb_rm_lane_release_tracker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rm_lane_release_tracker_pkg.sv
// Shared types for the runtime-monitor lane release tracker: lane FSM states,
// the per-slot record and the PC width used throughout.
package rm_lane_release_tracker_pkg;

  localparam int unsigned VLEN = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } rm_lane_state_e;

  typedef struct packed {
    logic            v;
    logic            c;
    logic [VLEN-1:0] pc;
  } rm_lane_slot_t;

endpackage

// File: rtl/rm_lane_slot_fsm.sv
// One lane of the release tracker: two PC slots, the lane FSM, the hold timer
// that waits for a late slot1 allocation, and the uncommitted-slot watchdog.
module rm_lane_slot_fsm
  import rm_lane_release_tracker_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_slot0,
  input  logic                 wr_slot1,
  input  logic [VLEN-1:0]      alloc_pc,
  input  logic [1:0]           commit_valid,
  input  logic [1:0][VLEN-1:0] commit_pc,
  input  logic                 flush,
  output logic                 lane_reset,
  output logic                 busy,
  output logic                 wd_expire
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX    = WW'(WATCHDOG_CYCLES);

  rm_lane_state_e       state, state_next;
  rm_lane_slot_t [1:0]  slots, slots_next;
  logic [HW-1:0]        hold_cnt;
  logic [WW-1:0]        wd_cnt;
  logic [1:0]           slot_match;
  logic                 alloc_commit;
  logic                 pending;
  logic                 any_write;
  logic                 all_done;
  logic                 single_done;

  // A commit port can complete a slot already held or the PC being written now.
  always_comb begin
    alloc_commit = 1'b0;
    slot_match   = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (commit_valid[p] && (commit_pc[p] == alloc_pc)) alloc_commit = 1'b1;
      for (int s = 0; s < 2; s++) begin
        if (commit_valid[p] && slots[s].v && !slots[s].c && (commit_pc[p] == slots[s].pc))
          slot_match[s] = 1'b1;
      end
    end
  end

  always_comb begin
    slots_next = slots;
    for (int s = 0; s < 2; s++) begin
      if (slot_match[s]) slots_next[s].c = 1'b1;
    end
    if (state == RELEASE) slots_next = '0;
    if (wr_slot0) slots_next[0] = '{v: 1'b1, c: alloc_commit, pc: alloc_pc};
    if (wr_slot1) slots_next[1] = '{v: 1'b1, c: alloc_commit, pc: alloc_pc};
  end

  assign busy      = slots[0].v | slots[1].v;
  assign any_write = wr_slot0 | wr_slot1;
  assign pending   = (slots[0].v & ~slots[0].c) | (slots[1].v & ~slots[1].c);
  assign wd_expire = (state == ACTIVE) && pending && (slot_match == 2'b00) &&
                     (wd_cnt == WD_LAST) && !flush;

  always_comb begin
    all_done    = slots_next[1].v && slots_next[1].c && (!slots_next[0].v || slots_next[0].c);
    single_done = !slots_next[1].v && slots_next[0].v && slots_next[0].c;
    state_next  = state;
    unique case (state)
      IDLE:    if (any_write) state_next = ACTIVE;
      ACTIVE: begin
        if (wd_expire || all_done) state_next = RELEASE;
        else if (single_done)      state_next = HOLD;
      end
      HOLD: begin
        if (any_write)                  state_next = ACTIVE;
        else if (hold_cnt == HOLD_LAST) state_next = RELEASE;
      end
      RELEASE: state_next = any_write ? ACTIVE : IDLE;
      default: state_next = IDLE;
    endcase
    // A flush drops every lane still holding anything, committed or not.
    if (flush && (state != RELEASE) && ((state != IDLE) || busy)) state_next = RELEASE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      slots      <= '0;
      hold_cnt   <= '0;
      wd_cnt     <= '0;
      lane_reset <= 1'b0;
    end else begin
      state      <= state_next;
      slots      <= slots_next;
      lane_reset <= (state == RELEASE);
      hold_cnt   <= ((state == HOLD) && (state_next == HOLD)) ? hold_cnt + HW'(1) : '0;
      if ((state == RELEASE) || !pending || (slot_match != 2'b00)) wd_cnt <= '0;
      else if (wd_cnt != WD_MAX)                                    wd_cnt <= wd_cnt + WW'(1);
    end
  end

endmodule

// File: rtl/rm_lane_release_tracker.sv
// Turns allocator descriptors and commits into per-lane release pulses; the
// per-lane tracking lives in rm_lane_slot_fsm, this level decodes and counts.
module rm_lane_release_tracker
  import rm_lane_release_tracker_pkg::*;
#(
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned WATCHDOG_CYCLES = 1024,
  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_valid_i,
  input  logic [LW-1:0]        alloc_lane0_i,
  input  logic [LW-1:0]        alloc_lane1_i,
  input  logic                 alloc_two_lane_i,
  input  logic [VLEN-1:0]      alloc_pc_i,
  input  logic [1:0]           commit_valid_i,
  input  logic [1:0][VLEN-1:0] commit_pc_i,
  input  logic                 flush_i,
  output logic [NUM_LANES-1:0] lane_reset_o,
  output logic [NUM_LANES-1:0] lane_busy_o,
  output logic [15:0]          timeout_cnt_o
);

  logic [NUM_LANES-1:0] wr_slot0, wr_slot1, expire;
  logic                 alloc_ok;
  logic [16:0]          timeout_sum;
  logic [15:0]          timeout_cnt;

  assign alloc_ok = alloc_valid_i & ~flush_i;

  // A two-lane instruction takes slot1 of its primary lane and slot0 of the secondary.
  always_comb begin
    wr_slot0 = '0;
    wr_slot1 = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      wr_slot0[i] = alloc_ok && (alloc_two_lane_i ? (alloc_lane1_i == LW'(i))
                                                  : (alloc_lane0_i == LW'(i)));
      wr_slot1[i] = alloc_ok && alloc_two_lane_i && (alloc_lane0_i == LW'(i));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : gen_lane
    rm_lane_slot_fsm #(
      .HOLD_CYCLES    (HOLD_CYCLES),
      .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wr_slot0    (wr_slot0[g]),
      .wr_slot1    (wr_slot1[g]),
      .alloc_pc    (alloc_pc_i),
      .commit_valid(commit_valid_i),
      .commit_pc   (commit_pc_i),
      .flush       (flush_i),
      .lane_reset  (lane_reset_o[g]),
      .busy        (lane_busy_o[g]),
      .wd_expire   (expire[g])
    );
  end

  always_comb begin
    timeout_sum = {1'b0, timeout_cnt};
    for (int i = 0; i < NUM_LANES; i++) timeout_sum = timeout_sum + 17'(expire[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timeout_cnt <= '0;
    else         timeout_cnt <= timeout_sum[16] ? 16'hFFFF : timeout_sum[15:0];
  end

  assign timeout_cnt_o = timeout_cnt;

endmodule

// File: tb/tb_rm_lane_release_tracker.sv
// Directed bench for rm_lane_release_tracker: expected release pulses are queued
// with their due cycle and compared every cycle against lane_reset_o.
module tb_rm_lane_release_tracker;
  import rm_lane_release_tracker_pkg::*;

  localparam int HOLD = 8;
  localparam int WD   = 1024;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 alloc_valid_i = 1'b0;
  logic [1:0]           alloc_lane0_i = '0;
  logic [1:0]           alloc_lane1_i = '0;
  logic                 alloc_two_lane_i = 1'b0;
  logic [VLEN-1:0]      alloc_pc_i = '0;
  logic [1:0]           commit_valid_i = '0;
  logic [1:0][VLEN-1:0] commit_pc_i = '0;
  logic                 flush_i = 1'b0;
  logic [3:0]           lane_reset_o;
  logic [3:0]           lane_busy_o;
  logic [15:0]          timeout_cnt_o;

  typedef struct {
    int         cycle;
    logic [3:0] value;
  } exp_t;

  exp_t scoreboard[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   n;

  rm_lane_release_tracker #(
    .NUM_LANES      (4),
    .HOLD_CYCLES    (HOLD),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .alloc_valid_i   (alloc_valid_i),
    .alloc_lane0_i   (alloc_lane0_i),
    .alloc_lane1_i   (alloc_lane1_i),
    .alloc_two_lane_i(alloc_two_lane_i),
    .alloc_pc_i      (alloc_pc_i),
    .commit_valid_i  (commit_valid_i),
    .commit_pc_i     (commit_pc_i),
    .flush_i         (flush_i),
    .lane_reset_o    (lane_reset_o),
    .lane_busy_o     (lane_busy_o),
    .timeout_cnt_o   (timeout_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  // Advance one cycle and compare lane_reset_o against the scoreboard head.
  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    #1;
    cyc++;
    while (scoreboard.size() > 0 && scoreboard[0].cycle < cyc) begin
      e = scoreboard.pop_front();
      checkOutput("missed_pulse_slot", 32'(e.cycle), 32'(cyc));
    end
    if (scoreboard.size() > 0 && scoreboard[0].cycle == cyc) begin
      e = scoreboard.pop_front();
      checkOutput("lane_reset_pulse", 32'(lane_reset_o), 32'(e.value));
    end else begin
      checkOutput("lane_reset_quiet", 32'(lane_reset_o), 32'h0);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic expectPulse(input int at, input logic [3:0] value);
    scoreboard.push_back('{cycle: at, value: value});
  endtask

  task automatic applyStimulus(input logic av, input logic [1:0] l0, input logic [1:0] l1,
                               input logic two, input logic [VLEN-1:0] pc, input logic [1:0] cv,
                               input logic [VLEN-1:0] c0, input logic [VLEN-1:0] c1, input logic fl);
    alloc_valid_i    = av;
    alloc_lane0_i    = l0;
    alloc_lane1_i    = l1;
    alloc_two_lane_i = two;
    alloc_pc_i       = pc;
    commit_valid_i   = cv;
    commit_pc_i[0]   = c0;
    commit_pc_i[1]   = c1;
    flush_i          = fl;
    tick();
    alloc_valid_i    = 1'b0;
    alloc_two_lane_i = 1'b0;
    commit_valid_i   = 2'b00;
    flush_i          = 1'b0;
  endtask

  task automatic allocOne(input logic [1:0] lane, input logic [VLEN-1:0] pc);
    applyStimulus(1'b1, lane, 2'd0, 1'b0, pc, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic allocTwo(input logic [1:0] l0, input logic [1:0] l1, input logic [VLEN-1:0] pc);
    applyStimulus(1'b1, l0, l1, 1'b1, pc, 2'b00, '0, '0, 1'b0);
  endtask

  task automatic commitPcs(input logic [1:0] cv, input logic [VLEN-1:0] c0, input logic [VLEN-1:0] c1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, '0, cv, c0, c1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_lane_reset", 32'(lane_reset_o), 32'h0);
    checkOutput("reset_busy", 32'(lane_busy_o), 32'h0);
    checkOutput("reset_timeout", 32'(timeout_cnt_o), 32'h0);
    rst_ni = 1'b1;
    cyc = 0;

    // Single-lane path: commit at cycle 5 releases at 5+2+HOLD.
    allocOne(2'd2, 64'h8000_0100);
    checkOutput("single_busy", 32'(lane_busy_o), 32'h4);
    while (cyc < 5) tick();
    n = cyc;
    expectPulse(n + 2 + HOLD, 4'b0100);
    commitPcs(2'b01, 64'h8000_0100, '0);
    idle(HOLD);
    checkOutput("single_hold_busy", 32'(lane_busy_o), 32'h4);
    tick();
    checkOutput("single_cleared", 32'(lane_busy_o), 32'h0);
    idle(2);

    // Two-lane path: lane1 releases two cycles after its slot1 commit, lane3 holds.
    allocOne(2'd1, 64'h100);
    allocTwo(2'd1, 2'd3, 64'h104);
    checkOutput("two_lane_busy", 32'(lane_busy_o), 32'ha);
    commitPcs(2'b01, 64'h100, '0);
    idle(3);
    n = cyc;
    expectPulse(n + 2, 4'b0010);
    expectPulse(n + 2 + HOLD, 4'b1000);
    commitPcs(2'b10, '0, 64'h104);
    idle(1);
    checkOutput("two_lane_after_rel", 32'(lane_busy_o), 32'h8);
    idle(HOLD + 2);

    // Flush drops lanes 0 and 2 and the allocation presented alongside it.
    allocOne(2'd0, 64'h200);
    allocOne(2'd2, 64'h204);
    n = cyc;
    expectPulse(n + 2, 4'b0101);
    applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, 64'h300, 2'b00, '0, '0, 1'b1);
    tick();
    checkOutput("flush_busy_clear", 32'(lane_busy_o), 32'h0);
    idle(3);
    checkOutput("flush_alloc_dropped", 32'(lane_busy_o), 32'h0);

    // Dual commit on both ports completes lane0 in one cycle; lane2 then holds.
    allocOne(2'd0, 64'h400);
    allocTwo(2'd0, 2'd2, 64'h404);
    n = cyc;
    expectPulse(n + 2, 4'b0001);
    expectPulse(n + 2 + HOLD, 4'b0100);
    commitPcs(2'b11, 64'h400, 64'h404);
    idle(HOLD + 3);

    // Allocation and commit of the same PC in one cycle leave the slot committed.
    n = cyc;
    expectPulse(n + 3 + HOLD, 4'b1000);
    applyStimulus(1'b1, 2'd3, 2'd0, 1'b0, 64'h500, 2'b01, 64'h500, '0, 1'b0);
    idle(HOLD + 4);

    // A slot1 allocation during HOLD returns lane0 to ACTIVE and cancels the timer.
    allocOne(2'd0, 64'h600);
    commitPcs(2'b01, 64'h600, '0);
    idle(2);
    allocTwo(2'd0, 2'd1, 64'h604);
    idle(HOLD);
    checkOutput("hold_reactivated", 32'(lane_busy_o), 32'h3);
    n = cyc;
    expectPulse(n + 2, 4'b0001);
    expectPulse(n + 2 + HOLD, 4'b0010);
    commitPcs(2'b01, 64'h604, '0);
    idle(HOLD + 3);

    // Allocation landing in the RELEASE cycle survives the clear.
    allocOne(2'd3, 64'h900);
    n = cyc;
    expectPulse(n + 2 + HOLD, 4'b1000);
    commitPcs(2'b01, 64'h900, '0);
    idle(HOLD);
    allocOne(2'd3, 64'h904);
    checkOutput("release_alloc_kept", 32'(lane_busy_o), 32'h8);
    n = cyc;
    expectPulse(n + 2 + HOLD, 4'b1000);
    commitPcs(2'b10, '0, 64'h904);
    idle(HOLD + 3);

    // Watchdog: an allocation that never commits is forced out.
    checkOutput("timeout_before_wd", 32'(timeout_cnt_o), 32'h0);
    n = cyc;
    expectPulse(n + WD + 2, 4'b0010);
    allocOne(2'd1, 64'h700);
    idle(WD);
    checkOutput("wd_still_busy", 32'(lane_busy_o), 32'h2);
    tick();
    checkOutput("wd_timeout_cnt", 32'(timeout_cnt_o), 32'h1);
    checkOutput("wd_cleared", 32'(lane_busy_o), 32'h0);
    idle(2);

    // Reset while a lane sits in HOLD: everything clears, no pulse follows.
    allocOne(2'd2, 64'h800);
    commitPcs(2'b01, 64'h800, '0);
    idle(3);
    checkOutput("pre_reset_busy", 32'(lane_busy_o), 32'h4);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("mid_reset_lane_reset", 32'(lane_reset_o), 32'h0);
    checkOutput("mid_reset_busy", 32'(lane_busy_o), 32'h0);
    checkOutput("mid_reset_timeout", 32'(timeout_cnt_o), 32'h0);
    idle(2);
    rst_ni = 1'b1;
    idle(HOLD + 4);
    checkOutput("post_reset_busy", 32'(lane_busy_o), 32'h0);

    checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
